axis_pkt_sink: RTL

Synthesizable AXI-Stream packet consumer that terminates the master side of the stream FIFO. It accepts beats under a configurable back-pressure policy and accumulates per-packet length and a 16-bit data checksum. It reports each completed packet on a one-cycle result strobe. It is the reader counterpart to the UVC driver that feeds the FIFO's slave side, and it closes the loop in block-level and loopback benches.

---
 rtl/axis_pkt_sink.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axis_pkt_sink.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_sink
// Purpose  : AXI-Stream packet consumer with programmable back-pressure;
//            reports per-packet length, 16-bit checksum and length error.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_sink #(
    parameter int          WIDTH     = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S_AXIS_TVALID,
    input  logic [WIDTH-1:0] S_AXIS_TDATA,
    input  logic             S_AXIS_TLAST,
    output logic             S_AXIS_TREADY,
    input  logic [1:0]       cfg_ready_mode,
    input  logic [3:0]       cfg_ready_period,
    input  logic [15:0]      cfg_exp_len,
    output logic             pkt_done,
    output logic [15:0]      pkt_len,
    output logic [15:0]      pkt_sum,
    output logic             pkt_len_err,
    output logic [15:0]      pkt_count,
    output logic [31:0]      beat_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam logic [15:0] c_LEN_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic [3:0]  r_phase;
    logic        r_ready;
    logic [15:0] r_acc_len;
    logic [15:0] r_acc_sum;
    logic [15:0] r_exp_len;

    logic        w_accept;
    logic        w_complete;
    logic        w_ready_nxt;
    logic [15:0] w_data_ext;
    logic [15:0] w_len_nxt;
    logic [15:0] w_sum_nxt;
    logic [15:0] w_exp_nxt;
    logic [15:0] w_lfsr_nxt;

    assign S_AXIS_TREADY = r_ready;
    assign w_accept      = S_AXIS_TVALID && r_ready;
    assign w_data_ext    = 16'(S_AXIS_TDATA);
    assign w_lfsr_nxt    = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // Ready for the next cycle is decided from current-cycle state only,
    // so TREADY never depends combinationally on the upstream inputs.
    always_comb begin
        w_ready_nxt = 1'b0;
        unique case (cfg_ready_mode)
            2'd0:    w_ready_nxt = 1'b1;
            2'd1:    w_ready_nxt = 1'b0;
            2'd2:    w_ready_nxt = r_lfsr[0];
            default: w_ready_nxt = (r_phase == cfg_ready_period);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_acc_len;
        w_sum_nxt   = r_acc_sum;
        w_exp_nxt   = r_exp_len;
        w_complete  = 1'b0;
        if (w_accept) begin
            if (r_state == ST_IDLE) begin
                // First beat: a single-beat packet is checked against the live cfg value.
                w_len_nxt = 16'd1;
                w_sum_nxt = w_data_ext;
                w_exp_nxt = cfg_exp_len;
            end else begin
                w_len_nxt = (r_acc_len == c_LEN_MAX) ? r_acc_len : r_acc_len + 16'd1;
                w_sum_nxt = r_acc_sum + w_data_ext;
            end
            if (S_AXIS_TLAST) begin
                w_state_nxt = ST_IDLE;
                w_complete  = 1'b1;
            end else begin
                w_state_nxt = ST_RECV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= LFSR_SEED;
            r_phase     <= 4'd0;
            r_ready     <= 1'b0;
            r_acc_len   <= 16'd0;
            r_acc_sum   <= 16'd0;
            r_exp_len   <= 16'd0;
            pkt_done    <= 1'b0;
            pkt_len     <= 16'd0;
            pkt_sum     <= 16'd0;
            pkt_len_err <= 1'b0;
            pkt_count   <= 16'd0;
            beat_count  <= 32'd0;
        end else begin
            r_lfsr    <= w_lfsr_nxt;
            r_phase   <= (r_phase >= cfg_ready_period) ? 4'd0 : r_phase + 4'd1;
            r_ready   <= w_ready_nxt;
            r_acc_len <= w_len_nxt;
            r_acc_sum <= w_sum_nxt;
            r_exp_len <= w_exp_nxt;
            pkt_done  <= w_complete;
            if (w_accept) begin
                beat_count <= beat_count + 32'd1;
            end
            if (w_complete) begin
                pkt_len     <= w_len_nxt;
                pkt_sum     <= w_sum_nxt;
                pkt_len_err <= (w_exp_nxt != 16'd0) && (w_len_nxt != w_exp_nxt);
                pkt_count   <= pkt_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
